i2c_frame_sequencer: RTL and testbench
======================================

Name: i2c_frame_sequencer

Overview:
- Multi-channel frame sequencer sitting above the byte-level I2C master (start/stop/i2c_en/tx_data/ready handshake).
- Each channel carries its own register address, variable-length payload and request line. Game logic raises requests (ball state, lose info, future score/sync).
- The block arbitrates between channels, snapshots the selected payload, and sends one frame: START+device addr, reg addr, N data bytes, STOP.
- Adds NACK retry, clean abort with STOP, a ready watchdog, and queuing of requests that arrive while busy.

Parameters:
- NUM_CH, 2: number of request channels.
- MAX_BYTES, 5: maximum payload bytes per channel.
- DEV_ADDR, 8'hAA: device address byte sent with START.
- MAX_RETRY, 2: re-attempts after NACK before giving up.
- TIMEOUT_CYC, 100000: cycles allowed for any single ready transition.
- LEN_W, $clog2(MAX_BYTES+1): derived width of the length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel send request (pulse or level; latched).
- payload  in  NUM_CH*MAX_BYTES*8  channel c, byte b at [(c*MAX_BYTES+b)*8 +: 8]; byte 0 sent first.
- len  in  NUM_CH*LEN_W  payload byte count per channel.
- reg_addr  in  NUM_CH*8  slave register address per channel.
- abort  in  1  terminate current frame (e.g. ball reversed direction).
- ready  in  1  byte master idle/complete.
- nack  in  1  valid when ready rises after a byte; 1 = not acknowledged.
- start  out  1  START command qualifier.
- stop  out  1  STOP command qualifier.
- i2c_en  out  1  command valid.
- tx_data  out  8  byte for the master.
- busy  out  1  frame in progress.
- done  out  1  1-cycle pulse on successful frame.
- done_ch  out  $clog2(NUM_CH)  channel of the last done or err.
- err  out  1  1-cycle pulse: retries exhausted or timeout.
- state_led  out  8  one-hot state code.

Behaviour:
- Reset (synchronous, active-high): state IDLE; pending, retry count and watchdog cleared; all outputs 0 except state_led=8'h01. Reset mid-frame drops i2c_en immediately; no STOP is sent.
- Pending latch: req[c]=1 sets pend[c]. pend[c] clears only in the cycle its frame is snapshotted. A req on the active channel during its frame re-sets pend, giving exactly one follow-up frame.
- Arbitration: highest-index pending channel wins. Fixed priority, so lose info (ch1) beats ball state (ch0).
- Snapshot: on leaving IDLE, copy the channel's payload, len and reg_addr into internal registers. Later input changes do not affect the frame. len>MAX_BYTES is clamped to MAX_BYTES. len=0 sends addr+reg only.
- Command handshake (every byte): hold i2c_en=1 plus qualifiers and tx_data until ready=0 (accept), then wait for ready=1 (complete). Sample nack on that rising cycle.
- States:
  - IDLE: if any pend -> START_CMD, same cycle as the snapshot is taken; IDLE->START_CMD takes 1 cycle.
  - START_CMD: start=1, tx_data=DEV_ADDR; on accept -> WAIT.
  - WAIT: on ready=1 -> next phase per the counter (REG, DATA, STOP_CMD), or to the NACK path.
  - REG: tx_data=reg_addr.
  - DATA: tx_data=byte[idx]; idx increments on accept; after byte len-1 -> STOP_CMD.
  - STOP_CMD: stop=1; on accept -> STOP_WAIT.
  - STOP_WAIT: ready=1 -> DONE, RETRY, or IDLE according to the flag.
  - DONE: done=1 for 1 cycle -> IDLE.
- NACK path: any byte NACKed -> STOP_CMD with retry flag set. After STOP, if retry_cnt<MAX_RETRY, increment and resend from START_CMD with the same snapshot. Otherwise err=1 for 1 cycle -> IDLE. retry_cnt clears on each new snapshot.
- Abort: honoured in REG/DATA/WAIT (not START_CMD before accept) -> STOP_CMD, then IDLE. No done and no err; pend is unaffected.
- Watchdog: counts cycles while waiting on any ready edge and resets on each edge. At TIMEOUT_CYC: drop i2c_en, err=1, -> IDLE without STOP.
- busy=1 in every state except IDLE.
- done_ch updates with done or err.
- state_led codes: IDLE 01, START_CMD 02, WAIT 04, REG 08, DATA 10, STOP_CMD 20, STOP_WAIT 40, DONE 80.
- Simultaneous events:
  - abort and nack together: abort wins, no retry.
  - req and done in the same cycle: latched, serviced next.

Decomposition:
- Package i2c_seq_pkg: state_t enum, LED code constants, cmd_phase_t (START/REG/DATA/STOP).
- Sub-module i2c_req_arbiter: pend register and fixed-priority select. Outputs grant_valid and grant_idx, takes a clr_en/clr_idx input.
- FSM, snapshot, retry and watchdog logic stay in the top module.

Test Plan:
- Ch0 req, len=5, reg 00, bytes 01..05, master always ACKs -> tx_data sequence AA,00,01,02,03,04,05 with start on the first byte and stop on the last command; done=1 with done_ch=0.
- req[0] and req[1] in the same cycle (ch1 len=1, reg 04, byte 01) -> ch1 frame AA,04,01 first, then the ch0 frame; two done pulses, done_ch 1 then 0.
- NACK on the reg byte of the first two attempts, ACK on the third (MAX_RETRY=2) -> 3 STOPs, 3 STARTs, one done. NACK on all attempts -> err=1 after the 3rd STOP, no done.
- Abort asserted after data byte 2 of a ch0 frame -> STOP issued next, returns to IDLE, no done/err, busy falls.
- Master holds ready=1 without accepting, with TIMEOUT_CYC=50 -> err at cycle 50, i2c_en=0, IDLE. Reset asserted mid-DATA -> all outputs 0 next cycle.
- ch0 len=7 (clamped to 5) and len=0 -> 5 data bytes sent, and AA,00,STOP respectively.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C frame sequencer: one-hot state encoding (doubles
// as the state LED code) and the command phase tracked across WAIT.
package i2c_seq_pkg;

  localparam logic [7:0] LED_IDLE      = 8'h01;
  localparam logic [7:0] LED_START_CMD = 8'h02;
  localparam logic [7:0] LED_WAIT      = 8'h04;
  localparam logic [7:0] LED_REG       = 8'h08;
  localparam logic [7:0] LED_DATA      = 8'h10;
  localparam logic [7:0] LED_STOP_CMD  = 8'h20;
  localparam logic [7:0] LED_STOP_WAIT = 8'h40;
  localparam logic [7:0] LED_DONE      = 8'h80;

  typedef enum logic [7:0] {
    S_IDLE      = LED_IDLE,
    S_START_CMD = LED_START_CMD,
    S_WAIT      = LED_WAIT,
    S_REG       = LED_REG,
    S_DATA      = LED_DATA,
    S_STOP_CMD  = LED_STOP_CMD,
    S_STOP_WAIT = LED_STOP_WAIT,
    S_DONE      = LED_DONE
  } state_t;

  // Which command was last handed to the byte master.
  typedef enum logic [1:0] {
    PH_START,
    PH_REG,
    PH_DATA,
    PH_STOP
  } cmd_phase_t;

  // States that present a command (i2c_en high) to the byte master.
  function automatic logic is_cmd_state(state_t s);
    return (s == S_START_CMD) || (s == S_REG) || (s == S_DATA) || (s == S_STOP_CMD);
  endfunction

endpackage

// File: rtl/i2c_req_arbiter.sv
// Request latch and fixed-priority select (highest index wins).
// Ports: clk, reset (sync, active-high); req per channel (latched into pend);
// clr_en/clr_idx clear one pend bit when its frame is snapshotted;
// grant_valid/grant_idx are registered and track the pend register.
module i2c_req_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] clr_mask;
  logic [IDX_W-1:0]  idx_d;

  // A new req wins over the clear so a re-request during snapshot is kept.
  always_comb begin
    clr_mask = '0;
    idx_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      clr_mask[c] = clr_en && (clr_idx == IDX_W'(c));
    end
    pend_d = (pend & ~clr_mask) | req;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_d[c]) idx_d = IDX_W'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend        <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      pend        <= pend_d;
      grant_valid <= |pend_d;
      grant_idx   <= idx_d;
    end
  end

endmodule

// File: rtl/i2c_frame_sequencer.sv
// Multi-channel I2C frame sequencer above a byte-level master. Arbitrates
// channel requests, snapshots the winner and sends START+DEV_ADDR, reg addr,
// N data bytes, STOP, with NACK retry, abort and a ready watchdog.
// Ports: clk, reset (sync, active-high); req/payload/len/reg_addr per channel;
// abort; ready/nack from the byte master; start/stop/i2c_en/tx_data command
// to the master; busy, done, err, done_ch status; state_led one-hot state.
module i2c_frame_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned MAX_BYTES   = 5,
  parameter logic [7:0]  DEV_ADDR    = 8'hAA,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned LEN_W      = $clog2(MAX_BYTES + 1),
  localparam int unsigned IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             req,
  input  logic [NUM_CH*MAX_BYTES*8-1:0] payload,
  input  logic [NUM_CH*LEN_W-1:0]       len,
  input  logic [NUM_CH*8-1:0]           reg_addr,
  input  logic                          abort,
  input  logic                          ready,
  input  logic                          nack,
  output logic                          start,
  output logic                          stop,
  output logic                          i2c_en,
  output logic [7:0]                    tx_data,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              done_ch,
  output logic                          err,
  output logic [7:0]                    state_led
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t                   state, state_d;
  cmd_phase_t               phase, phase_d;
  logic [LEN_W-1:0]         idx, idx_d;
  logic                     retry_flag, retry_flag_d;
  logic                     abort_flag, abort_flag_d;
  logic [RC_W-1:0]          retry_cnt, retry_cnt_d;
  logic [WD_W-1:0]          wd_cnt;
  logic                     waiting;
  logic                     snap_take;
  logic                     err_d;
  logic [7:0]               tx_d;
  logic [7:0]               data_byte;

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;

  logic [MAX_BYTES*8-1:0]   snap_data;
  logic [LEN_W-1:0]         snap_len;
  logic [7:0]               snap_reg;
  logic [IDX_W-1:0]         snap_ch;

  int unsigned              sel_base;
  logic [MAX_BYTES*8-1:0]   sel_data;
  logic [LEN_W-1:0]         sel_len;
  logic [7:0]               sel_reg;

  i2c_req_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .clr_en      (snap_take),
    .clr_idx     (grant_idx),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Granted channel's inputs, length clamped to MAX_BYTES.
  always_comb begin
    sel_base = 32'(grant_idx);
    sel_data = payload[sel_base*MAX_BYTES*8 +: MAX_BYTES*8];
    sel_reg  = reg_addr[sel_base*8 +: 8];
    sel_len  = len[sel_base*LEN_W +: LEN_W];
    if (sel_len > LEN_W'(MAX_BYTES)) sel_len = LEN_W'(MAX_BYTES);
  end

  // Data byte for the next DATA command.
  always_comb begin
    data_byte = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (idx_d == LEN_W'(b)) data_byte = snap_data[b*8 +: 8];
    end
  end

  assign waiting = (state != S_IDLE) && (state != S_DONE);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    phase_d      = phase;
    idx_d        = idx;
    retry_flag_d = retry_flag;
    abort_flag_d = abort_flag;
    retry_cnt_d  = retry_cnt;
    snap_take    = 1'b0;
    err_d        = 1'b0;
    tx_d         = 8'h00;

    unique case (state)
      S_IDLE: begin
        if (grant_valid) begin
          state_d      = S_START_CMD;
          snap_take    = 1'b1;
          phase_d      = PH_START;
          idx_d        = '0;
          retry_flag_d = 1'b0;
          abort_flag_d = 1'b0;
          retry_cnt_d  = '0;
        end
      end
      S_START_CMD: begin
        if (!ready) begin
          state_d = S_WAIT;
          phase_d = PH_START;
        end
      end
      S_WAIT: begin
        // Abort with a byte still in flight waits for completion before STOP.
        if (abort || abort_flag) begin
          abort_flag_d = 1'b1;
          if (ready) begin
            state_d      = S_STOP_CMD;
            retry_flag_d = 1'b0;
          end
        end else if (ready) begin
          if (nack) begin
            state_d      = S_STOP_CMD;
            retry_flag_d = 1'b1;
          end else begin
            unique case (phase)
              PH_START: state_d = S_REG;
              PH_REG:   state_d = (snap_len == '0) ? S_STOP_CMD : S_DATA;
              PH_DATA:  state_d = (idx == snap_len) ? S_STOP_CMD : S_DATA;
              default:  state_d = S_STOP_CMD;
            endcase
          end
        end
      end
      S_REG: begin
        if (abort) begin
          state_d      = S_STOP_CMD;
          abort_flag_d = 1'b1;
        end else if (!ready) begin
          state_d = S_WAIT;
          phase_d = PH_REG;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d      = S_STOP_CMD;
          abort_flag_d = 1'b1;
        end else if (!ready) begin
          state_d = S_WAIT;
          phase_d = PH_DATA;
          idx_d   = idx + LEN_W'(1);
        end
      end
      S_STOP_CMD: begin
        if (!ready) begin
          state_d = S_STOP_WAIT;
          phase_d = PH_STOP;
        end
      end
      S_STOP_WAIT: begin
        if (ready) begin
          if (abort_flag) begin
            state_d      = S_IDLE;
            abort_flag_d = 1'b0;
          end else if (retry_flag) begin
            retry_flag_d = 1'b0;
            if (retry_cnt < RC_W'(MAX_RETRY)) begin
              retry_cnt_d = retry_cnt + RC_W'(1);
              state_d     = S_START_CMD;
              phase_d     = PH_START;
              idx_d       = '0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog: no ready edge for TIMEOUT_CYC cycles drops the frame, no STOP.
    if (waiting && (state_d == state) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1))) begin
      state_d      = S_IDLE;
      err_d        = 1'b1;
      retry_flag_d = 1'b0;
      abort_flag_d = 1'b0;
    end

    unique case (state_d)
      S_START_CMD: tx_d = DEV_ADDR;
      S_REG:       tx_d = snap_reg;
      S_DATA:      tx_d = data_byte;
      default:     tx_d = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Frame control registers; watchdog restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= PH_START;
      idx        <= '0;
      retry_flag <= 1'b0;
      abort_flag <= 1'b0;
      retry_cnt  <= '0;
      wd_cnt     <= '0;
    end else begin
      phase      <= phase_d;
      idx        <= idx_d;
      retry_flag <= retry_flag_d;
      abort_flag <= abort_flag_d;
      retry_cnt  <= retry_cnt_d;
      wd_cnt     <= (!waiting || (state_d != state)) ? '0 : wd_cnt + WD_W'(1);
    end
  end

  // Snapshot of the granted channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_data <= '0;
      snap_len  <= '0;
      snap_reg  <= 8'h00;
      snap_ch   <= '0;
    end else if (snap_take) begin
      snap_data <= sel_data;
      snap_len  <= sel_len;
      snap_reg  <= sel_reg;
      snap_ch   <= grant_idx;
    end
  end

  // Registered outputs, aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      start     <= 1'b0;
      stop      <= 1'b0;
      i2c_en    <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      done_ch   <= '0;
      state_led <= LED_IDLE;
    end else begin
      start     <= (state_d == S_START_CMD);
      stop      <= (state_d == S_STOP_CMD);
      i2c_en    <= is_cmd_state(state_d);
      tx_data   <= tx_d;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      err       <= err_d;
      state_led <= 8'(state_d);
      if ((state_d == S_DONE) || err_d) done_ch <= snap_ch;
    end
  end

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Self-checking bench: byte-master model with a command scoreboard and a
// done/err event scoreboard, plus per-scenario tasks.
module tb_i2c_frame_sequencer;

  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned MAX_BYTES = 5;
  localparam int unsigned LEN_W     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset;
  logic [NUM_CH-1:0]             req;
  logic [NUM_CH*MAX_BYTES*8-1:0] payload;
  logic [NUM_CH*LEN_W-1:0]       len;
  logic [NUM_CH*8-1:0]           reg_addr;
  logic                          abort;
  logic                          ready;
  logic                          nack;
  logic                          start, stop, i2c_en, busy, done, err;
  logic [7:0]                    tx_data;
  logic [0:0]                    done_ch;
  logic [7:0]                    state_led;

  i2c_frame_sequencer #(
    .NUM_CH      (NUM_CH),
    .MAX_BYTES   (MAX_BYTES),
    .DEV_ADDR    (8'hAA),
    .MAX_RETRY   (2),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .payload   (payload),
    .len       (len),
    .reg_addr  (reg_addr),
    .abort     (abort),
    .ready     (ready),
    .nack      (nack),
    .start     (start),
    .stop      (stop),
    .i2c_en    (i2c_en),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .done_ch   (done_ch),
    .err       (err),
    .state_led (state_led)
  );

  typedef struct packed { logic start; logic stop; logic [7:0] data; } cmd_t;
  typedef struct packed { logic is_err; logic ch; } evt_t;

  cmd_t exp_cmd_q[$];
  evt_t exp_evt_q[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_reg   [NUM_CH];
  int         m_len   [NUM_CH];
  logic [7:0] m_bytes [NUM_CH][MAX_BYTES];

  int cap_cnt       = 0;
  int nack_reg_left = 0;
  bit hang          = 1'b0;
  bit sb_on         = 1'b1;

  // Program one channel's inputs and the bench's copy of them.
  task automatic apply_ch(input int c, input logic [7:0] r, input int n, input logic [7:0] base);
    m_reg[c] = r;
    m_len[c] = n;
    reg_addr[c*8 +: 8] = r;
    len[c*LEN_W +: LEN_W] = LEN_W'(n);
    for (int b = 0; b < MAX_BYTES; b++) begin
      m_bytes[c][b] = base + 8'(b);
      payload[(c*MAX_BYTES + b)*8 +: 8] = base + 8'(b);
    end
  endtask

  function automatic void push_cmd(input logic s, input logic p, input logic [7:0] d);
    cmd_t e;
    e.start = s; e.stop = p; e.data = d;
    exp_cmd_q.push_back(e);
  endfunction

  // One attempt: full frame, or AA + reg + STOP when the reg byte is NACKed.
  function automatic void push_attempt(input int c, input bit full);
    int n;
    n = (m_len[c] > MAX_BYTES) ? MAX_BYTES : m_len[c];
    push_cmd(1'b1, 1'b0, 8'hAA);
    push_cmd(1'b0, 1'b0, m_reg[c]);
    if (full) for (int b = 0; b < n; b++) push_cmd(1'b0, 1'b0, m_bytes[c][b]);
    push_cmd(1'b0, 1'b1, 8'h00);
  endfunction

  function automatic void push_evt(input bit e, input int c);
    evt_t v;
    v.is_err = e; v.ch = 1'(c);
    exp_evt_q.push_back(v);
  endfunction

  // Byte-master model: accepts a command, completes it two cycles later.
  initial begin
    cmd_t e;
    int   pos;
    int   lat;
    logic nack_next;
    ready = 1'b1; nack = 1'b0; pos = 0; lat = 0; nack_next = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ready = 1'b1; nack = 1'b0; lat = 0;
      end else if (ready && i2c_en && !hang) begin
        cap_cnt++;
        if (start) pos = 0; else pos++;
        nack_next = 1'b0;
        if (pos == 1 && !stop && nack_reg_left > 0) begin
          nack_next = 1'b1;
          nack_reg_left--;
        end
        if (sb_on) begin
          vectors++;
          if (exp_cmd_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_unexpected: got start=%b stop=%b data=%02h, required no command", start, stop, tx_data);
          end else begin
            e = exp_cmd_q.pop_front();
            if (start !== e.start || stop !== e.stop || (!e.stop && tx_data !== e.data)) begin
              miscompares++;
              $display("FAIL cmd: got start=%b stop=%b data=%02h, required start=%b stop=%b data=%02h",
                       start, stop, tx_data, e.start, e.stop, e.data);
            end
          end
        end
        ready = 1'b0; nack = 1'b0; lat = 2;
      end else if (!ready) begin
        if (lat == 0) begin
          ready = 1'b1; nack = nack_next;
        end else begin
          lat--;
        end
      end
    end
  end

  // done/err event scoreboard.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (!reset && (done || err)) begin
        vectors++;
        if (exp_evt_q.size() == 0) begin
          miscompares++;
          $display("FAIL evt_unexpected: got done=%b err=%b ch=%0d, required none", done, err, done_ch);
        end else begin
          e = exp_evt_q.pop_front();
          if ({done, err} !== (e.is_err ? 2'b01 : 2'b10) || done_ch !== e.ch) begin
            miscompares++;
            $display("FAIL evt: got done=%b err=%b ch=%0d, required done=%b err=%b ch=%0d",
                     done, err, done_ch, !e.is_err, e.is_err, e.ch);
          end
        end
      end
    end
  end

  task automatic pulse_req(input logic [NUM_CH-1:0] r);
    @(negedge clk); req = r;
    @(negedge clk); req = '0;
  endtask

  // Wait for both scoreboards to drain and the DUT to settle in IDLE.
  task automatic wait_quiet(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && (busy || exp_evt_q.size() != 0 || exp_cmd_q.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (k >= budget || busy !== 1'b0 || state_led !== 8'h01) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b led=%02h evt_left=%0d cmd_left=%0d, required idle with none left",
               name, busy, state_led, exp_evt_q.size(), exp_cmd_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; abort = 1'b0; payload = '0; len = '0; reg_addr = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({start, stop, i2c_en, busy, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 000000", {start, stop, i2c_en, busy, done, err});
    end
    vectors++;
    if (tx_data !== 8'h00 || done_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: got tx=%02h ch=%0d, required 00/0", tx_data, done_ch);
    end
    vectors++;
    if (state_led !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_led: got %02h, required 01", state_led);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || i2c_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: got busy=%b en=%b, required 0/0", busy, i2c_en);
    end
  endtask

  task automatic test_single_frame();
    apply_ch(0, 8'h00, 5, 8'h01);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 0);
    pulse_req(2'b01);
    wait_quiet("single", 300);
  endtask

  task automatic test_priority();
    apply_ch(1, 8'h04, 1, 8'h01);
    push_attempt(1, 1'b1);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 1);
    push_evt(1'b0, 0);
    pulse_req(2'b11);
    wait_quiet("priority", 500);
  endtask

  task automatic test_retry();
    nack_reg_left = 2;
    push_attempt(0, 1'b0);
    push_attempt(0, 1'b0);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 0);
    pulse_req(2'b01);
    wait_quiet("retry_ok", 500);
    vectors++;
    if (nack_reg_left !== 0) begin
      miscompares++;
      $display("FAIL retry_ok_nacks: got %0d left, required 0", nack_reg_left);
    end
    nack_reg_left = 3;
    push_attempt(0, 1'b0);
    push_attempt(0, 1'b0);
    push_attempt(0, 1'b0);
    push_evt(1'b1, 0);
    pulse_req(2'b01);
    wait_quiet("retry_fail", 500);
    nack_reg_left = 0;
  endtask

  task automatic test_abort();
    int base;
    int k;
    apply_ch(0, 8'h00, 5, 8'h01);
    push_cmd(1'b1, 1'b0, 8'hAA);
    push_cmd(1'b0, 1'b0, 8'h00);
    push_cmd(1'b0, 1'b0, 8'h01);
    push_cmd(1'b0, 1'b0, 8'h02);
    push_cmd(1'b0, 1'b1, 8'h00);
    base = cap_cnt;
    k = 0;
    pulse_req(2'b01);
    while (k < 200 && cap_cnt < base + 4) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= 200) begin
      miscompares++;
      $display("FAIL abort_reach: got %0d commands, required 4", cap_cnt - base);
    end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_quiet("abort", 200);
  endtask

  task automatic test_timeout();
    int cnt;
    int k;
    hang = 1'b1;
    push_evt(1'b1, 0);
    @(negedge clk); req = 2'b01;
    @(negedge clk); req = '0;
    cnt = 0;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    vectors++;
    if (cnt != 50) begin
      miscompares++;
      $display("FAIL timeout_cycles: got %0d busy cycles, required 50", cnt);
    end
    vectors++;
    if (i2c_en !== 1'b0 || state_led !== 8'h01) begin
      miscompares++;
      $display("FAIL timeout_idle: got en=%b led=%02h, required 0/01", i2c_en, state_led);
    end
    hang = 1'b0;
    wait_quiet("timeout", 100);
  endtask

  task automatic test_reset_mid();
    int k;
    apply_ch(0, 8'h00, 5, 8'h01);
    sb_on = 1'b0;
    pulse_req(2'b01);
    k = 0;
    while (k < 200 && state_led !== 8'h10) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= 200) begin
      miscompares++;
      $display("FAIL reset_mid_reach: got led=%02h, required 10", state_led);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({start, stop, i2c_en, busy, done, err} !== 6'b0 || tx_data !== 8'h00 || state_led !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_mid: got ctrl=%b tx=%02h led=%02h, required 000000/00/01",
               {start, stop, i2c_en, busy, done, err}, tx_data, state_led);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pend: got busy=%b, required 0", busy);
    end
    exp_cmd_q.delete();
    sb_on = 1'b1;
  endtask

  task automatic test_len_bounds();
    apply_ch(0, 8'h00, 7, 8'h01);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 0);
    pulse_req(2'b01);
    wait_quiet("len_clamp", 300);
    apply_ch(0, 8'h00, 0, 8'h01);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 0);
    pulse_req(2'b01);
    wait_quiet("len_zero", 200);
  endtask

  task automatic test_back_to_back();
    int k;
    int seen;
    apply_ch(0, 8'h10, 2, 8'h20);
    push_attempt(0, 1'b1);
    push_attempt(0, 1'b1);
    push_attempt(0, 1'b1);
    push_evt(1'b0, 0);
    push_evt(1'b0, 0);
    push_evt(1'b0, 0);
    pulse_req(2'b01);
    repeat (6) @(negedge clk);
    pulse_req(2'b01);
    k = 0;
    seen = 0;
    while (k < 400 && seen < 2) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen != 2) begin
      miscompares++;
      $display("FAIL b2b_two_done: got %0d done pulses, required 2", seen);
    end
    req = 2'b01;
    @(negedge clk); req = '0;
    wait_quiet("b2b", 400);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_priority();
    test_retry();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_len_bounds();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
